// File: rtl/gate_bist_pkg.sv
// Shared types and reference truth tables for the 2-input gate self-test engine.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef logic [1:0] vec_t;

    // Bit i holds the expected y for input vector {a,b} = i.
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_bist_settle_tmr.sv
// Loadable down-counter with a zero flag; times the settle window after each vector.
module gate_bist_settle_tmr #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero_c
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_checker.sv
// Self-test engine for a 2-input gate: sweeps {a,b}, samples y, counts truth-table mismatches.
// Optional first-failure log enabled by defining GATE_BIST_ERRLOG_EN.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       truth_table,
    input  logic             dut_y,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef GATE_BIST_ERRLOG_EN
    ,
    output logic             first_fail_vld,
    output logic [1:0]       first_fail_vec
`endif
);

    localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    vec_t              idx_q;
    logic [PASS_W-1:0] pass_q;
    logic [3:0]        tt_q;
    logic              tmr_zero_c;
    logic              start_ok_c;
    logic              last_pass_c;
    logic              mismatch_c;

    assign start_ok_c  = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_pass_c = (pass_q == PASS_W'(PASSES - 1));
    assign mismatch_c  = (state_q == SAMPLE) && (dut_y != tt_q[idx_q]);

    gate_bist_settle_tmr #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == APPLY),
        .dec    (state_q == SETTLE),
        .zero_c (tmr_zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = APPLY;
            APPLY:      state_d = SETTLE;
            SETTLE:     if (tmr_zero_c) state_d = SAMPLE;
            SAMPLE:     state_d = ((idx_q == 2'd3) && last_pass_c) ? DONE : APPLY;
            default:    state_d = IDLE;
        endcase
    end

    // Run context: latched table, vector/pass position and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q      <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
            err_count <= '0;
        end else if (start_ok_c) begin
            tt_q      <= truth_table;
            idx_q     <= '0;
            pass_q    <= '0;
            err_count <= '0;
        end else if (state_q == SAMPLE) begin
            if (mismatch_c && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (idx_q == 2'd3) begin
                idx_q <= '0;
                if (!last_pass_c) begin
                    pass_q <= pass_q + PASS_W'(1);
                end
            end else begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

`ifdef GATE_BIST_ERRLOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (start_ok_c) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (mismatch_c && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= idx_q;
        end
    end
`endif

    // Status and gate drive are a registered decode of the current state, so the
    // vector reaches the gate at the end of APPLY and settles for the whole SETTLE window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_a <= 1'b0;
            dut_b <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            if (state_q == APPLY) begin
                {dut_a, dut_b} <= idx_q;
            end else if ((state_q == IDLE) || (state_q == DONE)) begin
                {dut_a, dut_b} <= 2'b00;
            end
            busy <= (state_q == APPLY) || (state_q == SETTLE) || (state_q == SAMPLE);
            done <= (state_q == DONE);
            pass <= (state_q == DONE) && (err_count == '0);
        end
    end

endmodule
